// File: rtl/synth_audio_pkg.sv
// Shared audio types for the mixer, reverb and I2S blocks.
// Also holds the reverb FSM state enum and the sample saturation helper.
package synth_audio_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned PROD_W   = SAMPLE_W + 9;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0]   prod_t;

  localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(SAMPLE_W-1){1'b1}}});
  localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}});

  typedef enum logic [2:0] {CLEAR, IDLE, RD, MUL, SUM} rvb_state_t;

  // Clamp a wide signed value into the sample range.
  function automatic sample_t sat_sample(input prod_t x);
    if (x > prod_t'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (x < prod_t'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end else begin
      return sample_t'(x[SAMPLE_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/reverb_delay_ram.sv
// Single-port circular delay line: synchronous read, write enable, no reset on contents.
module reverb_delay_ram #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned WIDTH      = 24
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/reverb_echo.sv
// Feedback-delay reverb: wet = dry + g*echo, line <= dry + (g/2)*echo, one sample per 4 cycles.
// The delay line is zeroed after reset before any sample is accepted.
module reverb_echo
  import synth_audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  sample_t    dry_in,
  input  logic [7:0] reverb,
  output sample_t    wet_out,
  output logic       out_valid,
  output logic       busy,
  output logic       overrun
);

  rvb_state_t            r_state;
  logic [DEPTH_LOG2-1:0] r_ptr;
  sample_t               r_dry;
  logic [7:0]            r_g;
  prod_t                 r_pw;
  prod_t                 r_pf;
  sample_t               r_wet;
  logic                  r_valid;
  logic                  r_busy;

  sample_t w_rd_data;
  sample_t w_wr_data;
  sample_t w_wet;
  sample_t w_fb;
  prod_t   w_dry_ext;
  logic    w_we;

  assign w_dry_ext = prod_t'(r_dry);
  assign w_wet     = sat_sample(w_dry_ext + (r_pw >>> 8));
  assign w_fb      = sat_sample(w_dry_ext + (r_pf >>> 8));

  // CLEAR and SUM are the only write cycles; the address is always the pointer.
  assign w_we      = (r_state == CLEAR) || (r_state == SUM);
  assign w_wr_data = (r_state == SUM) ? w_fb : '0;

  assign overrun   = sample_tick && (r_state inside {RD, MUL, SUM});
  assign wet_out   = r_wet;
  assign out_valid = r_valid;
  assign busy      = r_busy;

  reverb_delay_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (SAMPLE_W)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_addr (r_ptr),
    .i_wdata(w_wr_data),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_dry   <= '0;
      r_g     <= '0;
      r_pw    <= '0;
      r_pf    <= '0;
      r_wet   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (&r_ptr) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          // busy stays high through the out_valid cycle of the previous sample
          r_busy <= sample_tick;
          if (sample_tick) begin
            r_dry   <= dry_in;
            r_g     <= reverb;
            r_state <= RD;
          end
        end
        RD: begin
          r_state <= MUL;
        end
        MUL: begin
          r_pw    <= prod_t'(w_rd_data) * prod_t'($signed({1'b0, r_g}));
          r_pf    <= prod_t'(w_rd_data) * prod_t'($signed({2'b00, r_g[7:1]}));
          r_state <= SUM;
        end
        SUM: begin
          r_wet   <= w_wet;
          r_valid <= 1'b1;
          r_ptr   <= r_ptr + 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reverb_echo.sv
// Bench for reverb_echo: a 4096-deep and a 16-deep instance share stimulus and are
// checked every cycle against a sample-level model of the echo line.
module tb_reverb_echo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_tick = 1'b0;
  logic [23:0] dry_in = '0;
  logic [7:0]  reverb = '0;

  logic [23:0] w_wet   [2];
  logic        w_valid [2];
  logic        w_busy  [2];
  logic        w_ovr   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  reverb_echo u_dut_big (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .dry_in     (dry_in),
    .reverb     (reverb),
    .wet_out    (w_wet[0]),
    .out_valid  (w_valid[0]),
    .busy       (w_busy[0]),
    .overrun    (w_ovr[0])
  );

  reverb_echo #(
    .DEPTH_LOG2(4)
  ) u_dut_small (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .dry_in     (dry_in),
    .reverb     (reverb),
    .wet_out    (w_wet[1]),
    .out_valid  (w_valid[1]),
    .busy       (w_busy[1]),
    .overrun    (w_ovr[1])
  );

  task automatic check(input string name, input int k, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d at %0t: got %0d (0x%h) expected %0d (0x%h)",
               name, k, $time, got, got[23:0], exp, exp[23:0]);
    end
  endtask

  function automatic logic signed [63:0] sx(input logic [23:0] v);
    return 64'($signed(v));
  endfunction

  // ---------------- behavioural model ----------------
  function automatic longint fdiv256(input longint x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  function automatic longint sat24(input longint x);
    if (x > 8388607) return 8388607;
    if (x < -8388608) return -8388608;
    return x;
  endfunction

  function automatic longint mix(input longint dry, input longint echo, input longint gain);
    return sat24(dry + fdiv256(echo * gain));
  endfunction

  longint mline [2][4096];
  int     dep [2] = '{4096, 16};
  int     mptr [2];
  longint pend_cyc [2];
  longint pend_wet [2];
  longint hold [2];
  longint last_acc [2];
  longint next_ok [2];
  longint n = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        check("rst_wet", k, sx(w_wet[k]), 0);
        check("rst_valid", k, 64'(w_valid[k]), 0);
        check("rst_busy", k, 64'(w_busy[k]), 1);
        check("rst_overrun", k, 64'(w_ovr[k]), 0);
        for (int a = 0; a < dep[k]; a++) mline[k][a] = 0;
        mptr[k] = 0;
        pend_cyc[k] = -1;
        pend_wet[k] = 0;
        hold[k] = 0;
        last_acc[k] = -100;
        next_ok[k] = 0;
      end else begin
        logic exp_valid, exp_busy, exp_ovr;
        exp_valid = (n == pend_cyc[k]);
        if (exp_valid) hold[k] = pend_wet[k];
        exp_busy = (n < dep[k]) || (n >= last_acc[k] + 1 && n <= last_acc[k] + 4);
        exp_ovr = 1'b0;
        if (sample_tick === 1'b1 && n >= dep[k]) begin
          if (n >= next_ok[k]) begin
            longint e, d, g;
            e = mline[k][mptr[k]];
            d = longint'($signed(dry_in));
            g = longint'(reverb);
            pend_wet[k] = mix(d, e, g);
            mline[k][mptr[k]] = mix(d, e, g / 2);
            mptr[k] = (mptr[k] + 1) % dep[k];
            pend_cyc[k] = n + 4;
            last_acc[k] = n;
            next_ok[k] = n + 4;
          end else begin
            exp_ovr = 1'b1;
          end
        end
        check("wet_out", k, sx(w_wet[k]), hold[k]);
        check("out_valid", k, 64'(w_valid[k]), 64'(exp_valid));
        check("busy", k, 64'(w_busy[k]), 64'(exp_busy));
        check("overrun", k, 64'(w_ovr[k]), 64'(exp_ovr));
      end
    end
    if (reset) n = 0;
    else n++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit tick, input logic [23:0] d, input logic [7:0] g);
    sample_tick = tick;
    dry_in = d;
    reverb = g;
    @(posedge clk);
    #1;
  endtask

  // Tick once, then scramble the inputs for the rest of the sample slot.
  task automatic send_tick(input logic [23:0] d, input logic [7:0] g);
    cyc(1'b1, d, g);
    repeat (3) cyc(1'b0, 24'($urandom), 8'($urandom));
  endtask

  function automatic logic [23:0] rand_dry();
    case ($urandom_range(0, 3))
      0: return 24'h7FFFFF;
      1: return 24'h800000;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    int cnt [2];
    bit done [2];

    check("model_half_echo", 0, mix(0, 'h100000, 128), 'h080000);
    check("model_floor", 0, mix(0, -1, 1), -1);
    check("model_sat_hi", 0, mix(8388607, 8388607, 255), 8388607);
    check("model_sat_lo", 0, mix(-8388608, -5, 127), -8388608);
    check("model_bypass", 0, mix('h123456, 777, 0), 'h123456);

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Busy length of CLEAR; random ticks meanwhile must be ignored by the clearing instance.
    cnt = '{0, 0};
    done = '{1'b0, 1'b0};
    for (int i = 0; i < 5000 && !(done[0] && done[1]); i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          if (w_busy[k] === 1'b1) cnt[k]++;
          else done[k] = 1'b1;
        end
      end
      cyc($urandom_range(0, 3) == 0, 24'($urandom), 8'($urandom));
    end
    check("clear_busy_cycles", 0, 64'(cnt[0]), 4096);
    check("clear_busy_cycles", 1, 64'(cnt[1]), 16);
    repeat (6) cyc(1'b0, 24'($urandom), 8'($urandom));

    // Bypass
    send_tick(24'h123456, 8'h00);
    for (int k = 0; k < 2; k++) begin
      check("bypass_valid", k, 64'(w_valid[k]), 1);
      check("bypass_wet", k, sx(w_wet[k]), 'h123456);
    end

    // Impulse on the deep line
    send_tick(24'h100000, 8'h80);
    for (int i = 1; i <= 8192; i++) begin
      send_tick(24'h000000, 8'h80);
      if (i == 4096) check("echo_4096", 0, sx(w_wet[0]), 'h080000);
      if (i == 8192) check("echo_8192", 0, sx(w_wet[0]), 'h020000);
      if (i == 100) check("no_echo_100", 0, sx(w_wet[0]), 0);
    end

    // Saturation both ways
    for (int i = 0; i < 4100; i++) send_tick(24'h7FFFFF, 8'hFF);
    for (int k = 0; k < 2; k++) check("sat_pos", k, sx(w_wet[k]), 'h7FFFFF);
    for (int i = 0; i < 4100; i++) send_tick(24'h800000, 8'hFF);
    for (int k = 0; k < 2; k++) check("sat_neg", k, sx(w_wet[k]), -8388608);

    // Tick at T and T+2
    cyc(1'b1, 24'h000ABC, 8'h40);
    cyc(1'b0, 24'($urandom), 8'($urandom));
    sample_tick = 1'b1;
    dry_in = 24'($urandom);
    #1;
    for (int k = 0; k < 2; k++) check("overrun_pulse", k, 64'(w_ovr[k]), 1);
    @(posedge clk);
    #1;
    cyc(1'b0, 24'($urandom), 8'($urandom));
    for (int k = 0; k < 2; k++) check("single_valid", k, 64'(w_valid[k]), 1);
    repeat (4) cyc(1'b0, 24'($urandom), 8'($urandom));

    // Random traffic, including back-to-back and overrunning ticks
    repeat (500) begin
      repeat ($urandom_range(0, 5)) cyc(1'b0, rand_dry(), 8'($urandom));
      cyc(1'b1, rand_dry(), 8'($urandom));
    end
    repeat (6) cyc(1'b0, 24'($urandom), 8'($urandom));

    // Reset while in MUL
    cyc(1'b1, 24'h100000, 8'h80);
    cyc(1'b0, 24'($urandom), 8'($urandom));
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_mul_wet", k, sx(w_wet[k]), 0);
      check("rst_mul_busy", k, 64'(w_busy[k]), 1);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) cyc(1'b0, 24'($urandom), 8'($urandom));

    // Short line wraps after 16 accepted ticks
    send_tick(24'h100000, 8'h80);
    for (int i = 1; i <= 32; i++) begin
      send_tick(24'h000000, 8'h80);
      if (i == 16) check("wrap_echo_16", 1, sx(w_wet[1]), 'h080000);
      if (i == 32) check("wrap_echo_32", 1, sx(w_wet[1]), 'h020000);
      if (i == 8) check("wrap_no_echo_8", 1, sx(w_wet[1]), 0);
    end
    repeat (4) cyc(1'b0, 24'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
